// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator SCAN scheduler
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_FLOOR_W = 4;

endpackage

// File: rtl/elevator_scan_scheduler_if.sv
// rtl/elevator_scan_scheduler_if.sv - call input and car status bundle
interface elevator_scan_scheduler_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic                  call_valid;
    logic [FLOOR_W-1:0]    call_floor;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  door_open;
    logic                  moving_up;
    logic                  moving_down;
    logic                  step;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    modport master (
        output call_valid, call_floor,
        input  cur_floor, door_open, moving_up, moving_down, step, pending, busy
    );

    modport slave (
        input  call_valid, call_floor,
        output cur_floor, door_open, moving_up, moving_down, step, pending, busy
    );
endinterface

// File: rtl/elevator_call_reg.sv
// rtl/elevator_call_reg.sv - pending call bitmask with set/clear arbitration and sweep lookahead
module elevator_call_reg
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [FLOOR_W-1:0]    set_idx,
    input  logic                  clear_en,
    input  logic                  clear_wins,
    input  logic [FLOOR_W-1:0]    pos,
    input  logic                  dir,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  pending_any_d,
    output logic                  at_pos,
    output logic                  ahead,
    output logic                  behind
);

    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] pos_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] below;
    logic [NUM_FLOORS-1:0] pending_d;

    always_comb begin
        set_mask = '0;
        pos_mask = '0;
        above    = '0;
        below    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            set_mask[i] = set_en && (set_idx == FLOOR_W'(i));
            pos_mask[i] = (pos == FLOOR_W'(i));
            above[i]    = pending[i] && (FLOOR_W'(i) > pos);
            below[i]    = pending[i] && (FLOOR_W'(i) < pos);
        end
        clr_mask = clear_en ? pos_mask : '0;
        // A clear issued while parked at the floor must beat a same-cycle call there.
        if (clear_wins)
            pending_d = (pending | set_mask) & ~clr_mask;
        else
            pending_d = (pending & ~clr_mask) | set_mask;
    end

    assign pending_any_d = |pending_d;
    assign at_pos        = |(pending & pos_mask);
    assign ahead         = (dir == DIR_UP) ? |above : |below;
    assign behind        = (dir == DIR_UP) ? |below : |above;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= pending_d;
    end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// rtl/elevator_scan_scheduler.sv - SCAN call scheduler: car FSM, position and travel/dwell timing
module elevator_scan_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 16,
    parameter int FLOOR_W       = DEFAULT_FLOOR_W,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    elevator_scan_scheduler_if.slave bus
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t             state;
    logic [FLOOR_W-1:0] cur_floor;
    logic               dir;
    logic [TW-1:0]      travel_cnt;
    logic [DW-1:0]      dwell_cnt;
    logic               door_open;
    logic               moving_up;
    logic               moving_down;
    logic               step;
    logic               busy;

    logic               travel_done;
    logic               at_limit;
    logic [FLOOR_W-1:0] next_floor;
    logic [FLOOR_W-1:0] pos_eval;
    logic               in_range;
    logic               absorb;
    logic               set_en;
    logic               clear_en;
    logic               pending_any_d;
    logic               at_pos;
    logic               ahead;
    logic               behind;
    logic               go_dir;

    assign travel_done = (travel_cnt == TW'(TRAVEL_CYCLES - 1));
    assign at_limit    = (dir == DIR_UP) ? (cur_floor == FLOOR_W'(NUM_FLOORS - 1))
                                         : (cur_floor == '0);
    assign next_floor  = at_limit ? cur_floor
                       : (dir == DIR_UP) ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
    // Arrival decisions are taken against the floor the car is stepping onto.
    assign pos_eval    = (state == ST_MOVE && travel_done) ? next_floor : cur_floor;

    assign in_range = ({1'b0, bus.call_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
    assign absorb   = bus.call_valid && (state == ST_DOOR) && (bus.call_floor == cur_floor);
    assign set_en   = bus.call_valid && in_range && !absorb;
    assign clear_en = at_pos && ((state == ST_IDLE) || (state == ST_MOVE && travel_done));
    assign go_dir   = ahead ? dir : ~dir;

    elevator_call_reg #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_reg (
        .clk           (clk),
        .reset         (reset),
        .set_en        (set_en),
        .set_idx       (bus.call_floor),
        .clear_en      (clear_en),
        .clear_wins    (state != ST_MOVE),
        .pos           (pos_eval),
        .dir           (dir),
        .pending       (bus.pending),
        .pending_any_d (pending_any_d),
        .at_pos        (at_pos),
        .ahead         (ahead),
        .behind        (behind)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cur_floor   <= '0;
            dir         <= DIR_UP;
            travel_cnt  <= '0;
            dwell_cnt   <= '0;
            door_open   <= 1'b1;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            step        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (at_pos) begin
                        state     <= ST_DOOR;
                        dwell_cnt <= DW'(DWELL_CYCLES - 1);
                        busy      <= 1'b1;
                    end else if (ahead || behind) begin
                        state       <= ST_MOVE;
                        dir         <= go_dir;
                        travel_cnt  <= '0;
                        door_open   <= 1'b0;
                        moving_up   <= (go_dir == DIR_UP);
                        moving_down <= (go_dir == DIR_DOWN);
                        busy        <= 1'b1;
                    end else begin
                        busy <= pending_any_d;
                    end
                end
                ST_MOVE: begin
                    if (travel_done) begin
                        travel_cnt <= '0;
                        cur_floor  <= next_floor;
                        step       <= 1'b1;
                        if (at_pos) begin
                            state       <= ST_DOOR;
                            dwell_cnt   <= DW'(DWELL_CYCLES - 1);
                            door_open   <= 1'b1;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                        end else if (!ahead && behind) begin
                            dir         <= ~dir;
                            moving_up   <= ~moving_up;
                            moving_down <= ~moving_down;
                        end else if (!ahead) begin
                            state       <= ST_IDLE;
                            door_open   <= 1'b1;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                            busy        <= pending_any_d;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + TW'(1);
                    end
                end
                ST_DOOR: begin
                    if (absorb) begin
                        dwell_cnt <= DW'(DWELL_CYCLES - 1);
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else if (ahead || behind) begin
                        state       <= ST_MOVE;
                        dir         <= go_dir;
                        travel_cnt  <= '0;
                        door_open   <= 1'b0;
                        moving_up   <= (go_dir == DIR_UP);
                        moving_down <= (go_dir == DIR_DOWN);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= pending_any_d;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sweep logic only keeps moving while a call lies ahead, so the car can never push past an end floor.
    always_ff @(posedge clk) begin
        if (reset && state == ST_MOVE)
            assert (!at_limit);
    end

    assign bus.cur_floor   = cur_floor;
    assign bus.door_open   = door_open;
    assign bus.moving_up   = moving_up;
    assign bus.moving_down = moving_down;
    assign bus.step        = step;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// tb/tb_elevator_scan_scheduler.sv - directed self-checking bench for elevator_scan_scheduler
module tb_elevator_scan_scheduler;

    localparam int NF = 12;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    elevator_scan_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_scan_scheduler #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (4),
        .DWELL_CYCLES  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic call(input int f);
        bus.call_valid = 1'b1;
        bus.call_floor = FW'(f);
        tick();
        bus.call_valid = 1'b0;
    endtask

    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.step && cnt < 64);
    endtask

    task automatic next_floor(input string tag, input int f);
        int c;
        wait_step(c);
        chk(tag, {bus.step, 27'd0, bus.cur_floor}, {1'b1, 27'd0, 4'(f)});
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (bus.busy && c < 200) begin
            tick();
            c++;
        end
        chk(tag, bus.busy, 0);
    endtask

    initial begin
        bus.call_valid = 1'b0;
        bus.call_floor = '0;

        tick();
        tick();
        chk("rst_cur", bus.cur_floor, 0);
        chk("rst_door", bus.door_open, 1);
        chk("rst_moving", {bus.moving_up, bus.moving_down, bus.step}, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b1;
        tick();

        // Idle at 0, call 3: three steps four clocks apart, then a 3-clock dwell.
        call(3);
        chk("c3_pending", bus.pending, 12'h008);
        chk("c3_busy", bus.busy, 1);
        chk("c3_still_idle", {bus.door_open, bus.moving_up}, 2'b10);
        tick();
        chk("c3_move", {bus.door_open, bus.moving_up, bus.moving_down}, 3'b010);
        for (int k = 1; k <= 3; k++) begin
            wait_step(n);
            chk("c3_gap", n, 4);
            chk("c3_floor", bus.cur_floor, k);
        end
        chk("c3_arrive", {bus.door_open, bus.moving_up, bus.busy}, 3'b101);
        chk("c3_cleared", bus.pending, 0);
        tick();
        tick();
        chk("c3_dwell", bus.busy, 1);
        tick();
        chk("c3_idle", bus.busy, 0);

        // Up to 7, then a call at the parked floor opens the door without a step.
        call(7);
        tick();
        next_floor("c7_f4", 4);
        next_floor("c7_f5", 5);
        next_floor("c7_f6", 6);
        next_floor("c7_f7", 7);
        wait_idle("c7_idle");
        call(7);
        chk("same_pending", bus.pending, 12'h080);
        tick();
        chk("same_door", {bus.door_open, bus.step, bus.moving_up, bus.moving_down}, 4'b1000);
        chk("same_cleared", bus.pending, 0);
        chk("same_floor", bus.cur_floor, 7);
        call(7);
        chk("absorb_pending", bus.pending, 0);
        tick();
        tick();
        chk("absorb_dwell", bus.busy, 1);
        tick();
        chk("absorb_idle", bus.busy, 0);

        // Asynchronous reset while the car travels down.
        call(2);
        tick();
        chk("rm_moving", {bus.moving_down, bus.pending}, {1'b1, 12'h004});
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rm_cur", bus.cur_floor, 0);
        chk("rm_outs", {bus.door_open, bus.moving_up, bus.moving_down, bus.step, bus.busy}, 5'b10000);
        chk("rm_pending", bus.pending, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Park at 2 heading up, then calls 5 and 1: sweep up to 5, reverse, down to 1.
        call(2);
        tick();
        next_floor("s_f1", 1);
        next_floor("s_f2", 2);
        wait_idle("s_park");
        call(5);
        call(1);
        chk("s_pending", bus.pending, 12'h022);
        chk("s_up", bus.moving_up, 1);
        next_floor("s_up3", 3);
        next_floor("s_up4", 4);
        next_floor("s_up5", 5);
        chk("s_at5_pending", bus.pending, 12'h002);
        next_floor("s_dn4", 4);
        chk("s_reversed", bus.moving_down, 1);
        next_floor("s_dn3", 3);
        next_floor("s_dn2", 2);
        next_floor("s_dn1", 1);
        chk("s_done_pending", bus.pending, 0);
        wait_idle("s_idle");

        // Out-of-range calls are dropped.
        call(15);
        chk("oor15_pending", bus.pending, 0);
        tick();
        chk("oor15_busy", {bus.busy, bus.moving_up, bus.moving_down}, 0);
        call(12);
        tick();
        chk("oor12", {bus.busy, bus.pending}, 0);

        // Repeated call to 4 from floor 1 heading down, plus a call at the departed floor.
        call(4);
        chk("rep_pending1", bus.pending, 12'h010);
        call(4);
        chk("rep_pending2", bus.pending, 12'h010);
        chk("rep_flip_up", bus.moving_up, 1);
        tick();
        call(1);
        chk("dep_latched", {bus.cur_floor, bus.pending}, {4'd1, 12'h012});
        next_floor("dep_f2", 2);
        next_floor("dep_f3", 3);
        next_floor("dep_f4", 4);
        chk("dep_at4_pending", bus.pending, 12'h002);
        next_floor("dep_b3", 3);
        next_floor("dep_b2", 2);
        next_floor("dep_b1", 1);
        chk("dep_done_pending", bus.pending, 0);
        wait_idle("dep_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
